round_timer_ctrl: RTL and testbench
===================================

Name: round_timer_ctrl

Overview:
Round sequencer that sits directly downstream of the 1 Hz 0..29 seconds counter. It consumes the counter's 5-bit count and closes the loop by driving that counter's game_start/game_on enables. It sequences IDLE/RUN/PAUSE/round-end/game-over across several rounds. It presents remaining seconds as two BCD digits for the seven-segment driver.

Parameters:
ROUND_LEN, 30, seconds per round; must equal upstream counter wrap value + 1 (range 2..31)
MAX_ROUNDS, 3, rounds per game (1..4)
WARN_SECS, 5, remaining-seconds threshold for warn output (used only with the optional feature)

Ports:
clk_1H  in  1  1 Hz game tick
reset  in  1  asynchronous, active-high; shared with upstream counter
start_btn  in  1  synchronized, debounced start level
pause_sw  in  1  synchronized pause switch level
count_in  in  5  elapsed-seconds count from upstream counter
game_start  out  1  latched game-started flag (upstream enable)
game_on  out  1  round-running flag (upstream enable)
secs_tens  out  4  BCD tens of remaining seconds
secs_ones  out  4  BCD ones of remaining seconds
round_num  out  2  current round, 0-based
round_done  out  1  one-tick pulse at round end
game_over  out  1  high once all rounds finished
warn  out  1  low-time warning

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk_1H. All state updates on posedge clk_1H.
- Reset values: state=IDLE, game_start=0, game_on=0, round_num=0, round_done=0, game_over=0, warn=0. Reset mid-round aborts to IDLE and does not preserve round_num.
- game_start: set on first tick with start_btn=1 in IDLE. Stays 1 until reset.
- FSM states: IDLE, RUN, PAUSED, ROUND_END, OVER. game_on=1 only in RUN (registered, decoded from state).
- IDLE: start_btn=1 -> RUN. Otherwise stay.
- RUN, count_in==ROUND_LEN-1 -> ROUND_END. Upstream wraps to 0 on the same edge, so the round is exactly ROUND_LEN ticks and the count is 0 for the next round.
- RUN, pause_sw=1 (and not at last second) -> PAUSED. Round-end has priority over pause when both occur on the same tick.
- PAUSED: count_in frozen upstream. pause_sw=0 -> RUN.
- ROUND_END: lasts one tick; round_done=1 during it.
  - If round_num==MAX_ROUNDS-1 -> OVER.
  - Else round_num+1 and -> IDLE; the next round needs a fresh start_btn.
  - start_btn is ignored in ROUND_END.
- OVER: game_on=0, game_over=1, terminal until reset. start_btn and pause_sw are ignored.
- Remaining-seconds display:
  - remaining = ROUND_LEN - count_in, 6-bit unsigned.
  - If count_in >= ROUND_LEN (illegal), clamp remaining to 0.
  - In OVER, display 0.
  - BCD conversion is combinational from remaining: tens = remaining/10, ones = remaining%10.
  - IDLE with count 0 shows 30.
- round_num saturates at MAX_ROUNDS-1 and never wraps.

Optional Feature:
WARN_BLINK_EN
- Defined: in RUN with remaining <= WARN_SECS, warn toggles every tick (registered), starting at 1 on the first qualifying tick. warn=0 in every other state and cleared by reset.
- Not defined: warn is tied to 0 and no toggle flop is instantiated.

Decomposition:
- Shared package game_pkg:
  - state enum (IDLE, RUN, PAUSED, ROUND_END, OVER), 3-bit encoding
  - constants ROUND_LEN_DEF=30, MAX_ROUNDS_DEF=3, WARN_SECS_DEF=5
  - BCD digit type (4-bit)
- One sub-module, bin2bcd_6b: purely combinational 6-bit binary to two BCD digits. It is reused by the score display.

Test Plan:
- Reset, start_btn=1 for 1 tick -> game_start=1, game_on=1 next tick. The attached counter runs 0..29 and the display shows 30 down to 01. On the tick after count 29: round_done=1, game_on=0, count=0, round_num=1.
- Start, then pause_sw=1 at count 10 for 5 ticks -> game_on=0 and count held at 10 / display 20 for 5 ticks. Release -> RUN resumes. Round ends 5 ticks later than without the pause.
- pause_sw rises on the same tick count==29 -> ROUND_END taken (round_done=1), not PAUSED. Next state is IDLE.
- Three full rounds with start presses -> after the third ROUND_END: game_over=1, display 00, round_num=2. A further start_btn has no effect.
- Assert reset at count 17, round 1 -> all outputs return to their reset values immediately (async). Counter reads 0, state is IDLE.
- With WARN_BLINK_EN: remaining 5,4,3,2,1 -> warn 1,0,1,0,1, then 0 in ROUND_END. Without the macro: warn=0 throughout.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and default constants for the round sequencer and its display helpers.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        PAUSED    = 3'd2,
        ROUND_END = 3'd3,
        OVER      = 3'd4
    } state_e;

    localparam int ROUND_LEN_DEF  = 30;
    localparam int MAX_ROUNDS_DEF = 3;
    localparam int WARN_SECS_DEF  = 5;

    typedef logic [3:0] bcd_t;

endpackage

// File: rtl/round_timer_ctrl_bin2bcd.sv
// Combinational 6-bit binary to two-digit BCD converter, shared with the score display.
module bin2bcd_6b
    import game_pkg::*;
(
    input  logic [5:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    assign tens_o = bcd_t'(bin_i / 6'd10);
    assign ones_o = bcd_t'(bin_i % 6'd10);

endmodule

// File: rtl/round_timer_ctrl.sv
// Multi-round game sequencer driving the upstream seconds counter enables and a BCD countdown.
// Optional low-time blink output enabled by defining WARN_BLINK_EN.
module round_timer_ctrl
    import game_pkg::*;
#(
    parameter int ROUND_LEN  = ROUND_LEN_DEF,
    parameter int MAX_ROUNDS = MAX_ROUNDS_DEF,
    parameter int WARN_SECS  = WARN_SECS_DEF
)(
    input  logic       clk_1H,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_sw,
    input  logic [4:0] count_in,
    output logic       game_start,
    output logic       game_on,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic [1:0] round_num,
    output logic       round_done,
    output logic       game_over,
    output logic       warn
);

    if (ROUND_LEN < 2 || ROUND_LEN > 31 || MAX_ROUNDS < 1 || MAX_ROUNDS > 4 ||
        WARN_SECS < 0 || WARN_SECS > ROUND_LEN) begin : g_bad_cfg
        $error("round_timer_ctrl: parameter out of range");
    end

    localparam logic [4:0] LAST_CNT = 5'(ROUND_LEN - 1);
    localparam logic [1:0] LAST_RND = 2'(MAX_ROUNDS - 1);
    localparam logic [5:0] RLEN6    = 6'(ROUND_LEN);

    state_e     state_q, state_d;
    logic       game_start_q, game_start_d;
    logic [1:0] round_q, round_d;
    logic       last_q, last_d;
    logic [5:0] remaining;

    always_ff @(posedge clk_1H or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            game_start_q <= 1'b0;
            round_q      <= 2'd0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            game_start_q <= game_start_d;
            round_q      <= round_d;
            last_q       <= last_d;
        end
    end

    // round_num advances as the round closes so ROUND_END already shows the next round;
    // last_q remembers whether the round that just closed was the final one.
    always_comb begin
        state_d      = state_q;
        game_start_d = game_start_q;
        round_d      = round_q;
        last_d       = last_q;
        unique case (state_q)
            IDLE: begin
                if (start_btn) begin
                    state_d      = RUN;
                    game_start_d = 1'b1;
                end
            end
            RUN: begin
                if (count_in == LAST_CNT) begin
                    state_d = ROUND_END;
                    last_d  = (round_q == LAST_RND);
                    if (round_q != LAST_RND) begin
                        round_d = round_q + 2'd1;
                    end
                end else if (pause_sw) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (!pause_sw) begin
                    state_d = RUN;
                end
            end
            ROUND_END: state_d = last_q ? OVER : IDLE;
            OVER:      state_d = OVER;
            default:   state_d = IDLE;
        endcase
    end

    assign game_start = game_start_q;
    assign game_on    = (state_q == RUN);
    assign round_done = (state_q == ROUND_END);
    assign game_over  = (state_q == OVER);
    assign round_num  = round_q;

    always_comb begin
        if (state_q == OVER || {1'b0, count_in} >= RLEN6) begin
            remaining = 6'd0;
        end else begin
            remaining = RLEN6 - {1'b0, count_in};
        end
    end

    bin2bcd_6b u_bcd (
        .bin_i  (remaining),
        .tens_o (secs_tens),
        .ones_o (secs_ones)
    );

`ifdef WARN_BLINK_EN
    // Phase flop rests at 1 outside the window so the first qualifying tick shows warn=1.
    logic warn_win;
    logic warn_ph_q, warn_ph_d;

    assign warn_win  = (state_q == RUN) && (remaining <= 6'(WARN_SECS));
    assign warn_ph_d = warn_win ? ~warn_ph_q : 1'b1;

    always_ff @(posedge clk_1H or posedge reset) begin
        if (reset) begin
            warn_ph_q <= 1'b1;
        end else begin
            warn_ph_q <= warn_ph_d;
        end
    end

    assign warn = warn_win & warn_ph_q;
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl with a behavioural model of the upstream 0..29 counter.
module tb_round_timer_ctrl;

`ifdef WARN_BLINK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic       clk_1H;
    logic       reset;
    logic       start_btn;
    logic       pause_sw;
    logic [4:0] count_in;
    logic       game_start, game_on, round_done, game_over, warn;
    logic [3:0] secs_tens, secs_ones;
    logic [1:0] round_num;

    logic [4:0] cnt_q;
    logic       ovr_en;
    logic [4:0] ovr_val;

    int n_cmp = 0;
    int n_bad = 0;

    round_timer_ctrl dut (
        .clk_1H     (clk_1H),
        .reset      (reset),
        .start_btn  (start_btn),
        .pause_sw   (pause_sw),
        .count_in   (count_in),
        .game_start (game_start),
        .game_on    (game_on),
        .secs_tens  (secs_tens),
        .secs_ones  (secs_ones),
        .round_num  (round_num),
        .round_done (round_done),
        .game_over  (game_over),
        .warn       (warn)
    );

    initial begin
        clk_1H = 1'b0;
        forever #5 clk_1H = ~clk_1H;
    end

    // Upstream seconds counter: runs only while the sequencer enables it, wraps 29 -> 0.
    always_ff @(posedge clk_1H or posedge reset) begin
        if (reset) begin
            cnt_q <= 5'd0;
        end else if (game_start && game_on) begin
            cnt_q <= (cnt_q == 5'd29) ? 5'd0 : cnt_q + 5'd1;
        end
    end

    assign count_in = ovr_en ? ovr_val : cnt_q;

    typedef struct {
        bit start;
        bit pause;
        int n;
        bit gs, on, done, over, wr;
        int rnd, cnt, disp;
    } vec_t;

    vec_t vecs[$];

    function void add(bit s, bit p, int n, bit gs, bit on, bit dn, bit ov, bit wr,
                      int rnd, int cnt, int disp);
        vec_t v;
        v.start = s; v.pause = p; v.n = n;
        v.gs = gs; v.on = on; v.done = dn; v.over = ov; v.wr = wr;
        v.rnd = rnd; v.cnt = cnt; v.disp = disp;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit gs, input bit on, input bit dn,
                           input bit ov, input bit wr, input int rnd, input int cnt,
                           input int disp);
        chk({tag, " game_start"}, int'(game_start), int'(gs));
        chk({tag, " game_on"},    int'(game_on),    int'(on));
        chk({tag, " round_done"}, int'(round_done), int'(dn));
        chk({tag, " game_over"},  int'(game_over),  int'(ov));
        chk({tag, " warn"},       int'(warn),       int'(wr));
        chk({tag, " round_num"},  int'(round_num),  rnd);
        chk({tag, " count"},      int'(count_in),   cnt);
        chk({tag, " secs_tens"},  int'(secs_tens),  disp / 10);
        chk({tag, " secs_ones"},  int'(secs_ones),  disp % 10);
    endtask

    task automatic tick();
        @(posedge clk_1H);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // Round 0: pause held 5 ticks at count 10, blink window at remaining 5..1.
        add(1,0, 1, 1,1,0,0,0,  0, 0,30);
        add(0,0, 1, 1,1,0,0,0,  0, 1,29);
        add(0,0, 8, 1,1,0,0,0,  0, 9,21);
        add(0,1, 1, 1,0,0,0,0,  0,10,20);
        add(0,1, 4, 1,0,0,0,0,  0,10,20);
        add(0,0, 1, 1,1,0,0,0,  0,10,20);
        add(0,0, 1, 1,1,0,0,0,  0,11,19);
        add(0,0,13, 1,1,0,0,0,  0,24, 6);
        add(0,0, 1, 1,1,0,0,WB, 0,25, 5);
        add(0,0, 1, 1,1,0,0,0,  0,26, 4);
        add(0,0, 1, 1,1,0,0,WB, 0,27, 3);
        add(0,0, 1, 1,1,0,0,0,  0,28, 2);
        add(0,0, 1, 1,1,0,0,WB, 0,29, 1);
        add(0,0, 1, 1,0,1,0,0,  1, 0,30);
        add(0,0, 1, 1,0,0,0,0,  1, 0,30);
        add(0,1, 2, 1,0,0,0,0,  1, 0,30);
        // Round 1: pause rises on the last second, round end wins.
        add(1,0, 1, 1,1,0,0,0,  1, 0,30);
        add(0,0,28, 1,1,0,0,0,  1,28, 2);
        add(0,0, 1, 1,1,0,0,WB, 1,29, 1);
        add(0,1, 1, 1,0,1,0,0,  2, 0,30);
        add(0,1, 1, 1,0,0,0,0,  2, 0,30);
        // Round 2: final round, then game over ignores start and pause.
        add(1,0, 1, 1,1,0,0,0,  2, 0,30);
        add(0,0,29, 1,1,0,0,WB, 2,29, 1);
        add(0,0, 1, 1,0,1,0,0,  2, 0,30);
        add(0,0, 1, 1,0,0,1,0,  2, 0, 0);
        add(1,0, 3, 1,0,0,1,0,  2, 0, 0);
        add(1,1, 2, 1,0,0,1,0,  2, 0, 0);

        reset = 1'b1; start_btn = 1'b0; pause_sw = 1'b0;
        ovr_en = 1'b0; ovr_val = 5'd0;
        #12;
        reset = 1'b0;
        #1;
        chk_all("reset", 0,0,0,0,0, 0, 0, 30);

        for (int i = 0; i < vecs.size(); i++) begin
            start_btn = vecs[i].start;
            pause_sw  = vecs[i].pause;
            repeat (vecs[i].n) tick();
            chk_all($sformatf("vec%0d", i), vecs[i].gs, vecs[i].on, vecs[i].done,
                    vecs[i].over, vecs[i].wr, vecs[i].rnd, vecs[i].cnt, vecs[i].disp);
        end
        start_btn = 1'b0;
        pause_sw  = 1'b0;

        // Display clamp for out-of-range counts, checked in IDLE after a fresh reset.
        #3 reset = 1'b1;
        #2 reset = 1'b0;
        ovr_en = 1'b1;
        ovr_val = 5'd31; #1; chk("clamp31 tens", int'(secs_tens), 0); chk("clamp31 ones", int'(secs_ones), 0);
        ovr_val = 5'd30; #1; chk("clamp30 tens", int'(secs_tens), 0); chk("clamp30 ones", int'(secs_ones), 0);
        ovr_val = 5'd29; #1; chk("cnt29 tens",   int'(secs_tens), 0); chk("cnt29 ones",   int'(secs_ones), 1);
        ovr_val = 5'd10; #1; chk("cnt10 tens",   int'(secs_tens), 2); chk("cnt10 ones",   int'(secs_ones), 0);
        ovr_val = 5'd0;  #1; chk("cnt0 tens",    int'(secs_tens), 3); chk("cnt0 ones",    int'(secs_ones), 0);
        ovr_en = 1'b0;

        // Asynchronous reset in round 1 at count 17.
        tick();
        start_btn = 1'b1; tick();
        start_btn = 1'b0; repeat (29) tick();
        tick();
        tick();
        chk_all("r1idle", 1,0,0,0,0, 1, 0, 30);
        start_btn = 1'b1; tick();
        start_btn = 1'b0; repeat (17) tick();
        chk_all("r1c17", 1,1,0,0,0, 1, 17, 13);
        #4 reset = 1'b1;
        #1;
        chk_all("async_rst", 0,0,0,0,0, 0, 0, 30);
        @(posedge clk_1H);
        #3 reset = 1'b0;
        tick();
        chk_all("post_rst", 0,0,0,0,0, 0, 0, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
